// File: rtl/mpmc11_state_machine_wb.sv
// mpmc11_state_machine_wb: per-channel request sequencer, FIFO pop -> preset delay -> write/read burst.
// Latency: pop is registered one cycle after a request is seen in IDLE; a burst lasts 1+PRESET_CYCLES+1+4 cycles minimum.
// Backpressure: holds in wait states on wdf_rdy, rdy and read progress; MPMC11_TIMEOUT_EN aborts a stuck wait.

package mpmc11_pkg;
  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    PRESET      = 4'd1,
    DECODE      = 4'd2,
    WRITE_DATA0 = 4'd3,
    WRITE_DATA1 = 4'd4,
    WRITE_DATA2 = 4'd5,
    WRITE_DATA3 = 4'd6,
    READ_DATA0  = 4'd7,
    READ_DATA1  = 4'd8,
    READ_DATA2  = 4'd9,
    WAIT_NACK   = 4'd10
  } state_t;
endpackage

module mpmc11_state_machine_wb #(
  parameter int PRESET_CYCLES = 3,
  parameter int NWAY          = 4,
  parameter int STRIP_W       = 6,
  parameter int TO_CYCLES     = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    wdf_rdy,
  input  logic                    fifo_empty,
  input  logic                    rd_rst_busy,
  input  logic                    fifo_stb,
  input  logic                    fifo_we,
  input  logic [STRIP_W-1:0]      num_strips,
  input  logic [STRIP_W-1:0]      req_strip_cnt,
  input  logic [STRIP_W-1:0]      resp_strip_cnt,
  input  logic                    rd_data_valid,
  output logic                    rd_fifo,
  output logic [3:0]              state,
  output logic [$clog2(NWAY)-1:0] wway,
  output logic [STRIP_W-1:0]      wstrip,
  output logic                    timed_out
);
  import mpmc11_pkg::*;

  localparam int WW = $clog2(NWAY);

  state_t     state_q;
  state_t     state_nxt;
  logic [3:0] pcnt_q;
  logic       enter_preset;
  logic       to_hit;

  assign state        = state_q;
  assign enter_preset = (state_q == IDLE) && (state_nxt == PRESET);

`ifdef MPMC11_TIMEOUT_EN
  logic [15:0] to_cnt_q;
  logic        wait_state;

  assign wait_state = (state_q == WRITE_DATA0) || (state_q == WRITE_DATA2) ||
                      (state_q == READ_DATA1)  || (state_q == READ_DATA2);
  assign to_hit     = wait_state && (to_cnt_q == 16'(TO_CYCLES - 1));

  // Count consecutive cycles held in a wait state; any state change restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q  <= '0;
      timed_out <= 1'b0;
    end else begin
      timed_out <= to_hit;
      if ((state_nxt != state_q) || !wait_state) to_cnt_q <= '0;
      else                                       to_cnt_q <= to_cnt_q + 16'd1;
    end
  end
`else
  // Without the time-out a wait state may hold indefinitely; the limit has no effect.
  logic [15:0] unused_to_limit;
  assign unused_to_limit = 16'(TO_CYCLES);
  assign to_hit          = 1'b0;
  assign timed_out       = 1'b0;
`endif

  // Next-state decode; a time-out overrides whatever the wait state would have done.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:        if (!fifo_empty && !rd_rst_busy) state_nxt = PRESET;
      PRESET:      if (pcnt_q == 4'(PRESET_CYCLES - 1)) state_nxt = DECODE;
      DECODE:      state_nxt = (fifo_stb && fifo_we) ? WRITE_DATA0 : READ_DATA0;
      WRITE_DATA0: if (wdf_rdy) state_nxt = WRITE_DATA1;
      WRITE_DATA1: state_nxt = WRITE_DATA2;
      WRITE_DATA2: if (rdy) state_nxt = WRITE_DATA3;
      WRITE_DATA3: state_nxt = (wstrip == num_strips) ? IDLE : WRITE_DATA0;
      READ_DATA0:  state_nxt = READ_DATA1;
      READ_DATA1:  if (rdy && (req_strip_cnt == num_strips)) state_nxt = READ_DATA2;
      READ_DATA2:  if (rd_data_valid && (resp_strip_cnt == num_strips)) state_nxt = WAIT_NACK;
      WAIT_NACK:   state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
    if (to_hit) state_nxt = IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  // Single-cycle pop on the first PRESET cycle, and the PRESET dwell counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_fifo <= 1'b0;
      pcnt_q  <= '0;
    end else begin
      rd_fifo <= enter_preset;
      if (enter_preset)           pcnt_q <= '0;
      else if (state_q == PRESET) pcnt_q <= pcnt_q + 4'd1;
    end
  end

  // Rotate the write way per request and step the write strip per completed strip.
  always_ff @(posedge clk) begin
    if (rst) begin
      wway   <= '0;
      wstrip <= '0;
    end else if (enter_preset) begin
      wway   <= (wway == WW'(NWAY - 1)) ? '0 : wway + WW'(1);
      wstrip <= '0;
    end else if ((state_q == WRITE_DATA3) && (state_nxt == WRITE_DATA0)) begin
      wstrip <= wstrip + STRIP_W'(1);
    end
  end

endmodule

// File: tb/tb_mpmc11_state_machine_wb.sv
`timescale 1ns/1ps
module tb_mpmc11_state_machine_wb;
  localparam int P    = 3;
  localparam int NW   = 4;
  localparam int SW   = 6;
  localparam int TO   = 8;
  localparam int MAXT = 256;

  localparam logic [3:0] S_IDLE = 4'd0, S_PRE = 4'd1, S_DEC = 4'd2;
  localparam logic [3:0] S_WD0 = 4'd3, S_WD1 = 4'd4, S_WD2 = 4'd5, S_WD3 = 4'd6;
  localparam logic [3:0] S_RD0 = 4'd7, S_RD1 = 4'd8, S_RD2 = 4'd9, S_WN = 4'd10;

  logic          clk = 1'b0;
  logic          rst, rdy, wdf_rdy, fifo_empty, rd_rst_busy, fifo_stb, fifo_we, rd_data_valid;
  logic [SW-1:0] num_strips, req_strip_cnt, resp_strip_cnt, wstrip;
  logic          rd_fifo, timed_out;
  logic [3:0]    state;
  logic [1:0]    wway;

  int checks = 0;
  int errors = 0;
  int exp_pops = 0;   // requests popped since last reset
  int exp_ws = 0;     // wstrip value the model expects while idle

  always #5 clk = ~clk;

  mpmc11_state_machine_wb #(
    .PRESET_CYCLES(P), .NWAY(NW), .STRIP_W(SW), .TO_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .wdf_rdy(wdf_rdy), .fifo_empty(fifo_empty),
    .rd_rst_busy(rd_rst_busy), .fifo_stb(fifo_stb), .fifo_we(fifo_we),
    .num_strips(num_strips), .req_strip_cnt(req_strip_cnt), .resp_strip_cnt(resp_strip_cnt),
    .rd_data_valid(rd_data_valid), .rd_fifo(rd_fifo), .state(state), .wway(wway),
    .wstrip(wstrip), .timed_out(timed_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request from IDLE back to IDLE. mode 0: random handshakes, 1: all ready, 2: rdy low 5 cycles in READ_DATA1.
  task automatic run_txn(input bit wr, input int ns, input int mode, input int exp_busy);
    bit         wdf_s[MAXT];
    bit         rdy_s[MAXT];
    bit         val_s[MAXT];
    int         req_s[MAXT];
    int         resp_s[MAXT];
    logic [3:0] es[MAXT];
    int         ews[MAXT];
    bit         epop[MAXT];
    int         t, len, busy, ww0, ww1;

    for (int i = 0; i < MAXT; i++) begin
      epop[i] = 1'b0;
      ews[i]  = 0;
      es[i]   = S_IDLE;
      if (mode == 0) begin
        wdf_s[i]  = (i % 4 == 3) || ($urandom_range(0, 3) != 0);
        rdy_s[i]  = (i % 4 == 3) || ($urandom_range(0, 3) != 0);
        val_s[i]  = (i % 4 == 3) || ($urandom_range(0, 3) != 0);
        req_s[i]  = ((i % 4 == 3) || ($urandom_range(0, 1) == 1)) ? ns : int'($urandom_range(0, ns));
        resp_s[i] = ((i % 4 == 3) || ($urandom_range(0, 1) == 1)) ? ns : int'($urandom_range(0, ns));
      end else begin
        wdf_s[i] = 1'b1; rdy_s[i] = 1'b1; val_s[i] = 1'b1;
        req_s[i] = ns;   resp_s[i] = ns;
      end
      if (mode == 2 && i >= P + 3 && i < P + 8) rdy_s[i] = 1'b0;
    end

    // Expected trace: each phase holds until the first cycle its handshake is satisfied.
    t = 0;
    es[t] = S_IDLE; ews[t] = exp_ws; t++;
    for (int p = 0; p < P; p++) begin es[t] = S_PRE; epop[t] = (p == 0); t++; end
    es[t] = S_DEC; t++;
    if (wr) begin
      for (int s = 0; s <= ns; s++) begin
        do begin es[t] = S_WD0; ews[t] = s; t++; end while (!wdf_s[t-1]);
        es[t] = S_WD1; ews[t] = s; t++;
        do begin es[t] = S_WD2; ews[t] = s; t++; end while (!rdy_s[t-1]);
        es[t] = S_WD3; ews[t] = s; t++;
      end
    end else begin
      es[t] = S_RD0; t++;
      do begin es[t] = S_RD1; t++; end while (!(rdy_s[t-1] && req_s[t-1] == ns));
      do begin es[t] = S_RD2; t++; end while (!(val_s[t-1] && resp_s[t-1] == ns));
      es[t] = S_WN; t++;
    end
    len = t;
    es[len]  = S_IDLE;
    ews[len] = wr ? ns : 0;
    ww0 = exp_pops % NW;
    ww1 = (exp_pops + 1) % NW;

    num_strips = SW'(ns);
    busy = 0;
    for (int i = 0; i <= len; i++) begin
      chk("state", state, es[i]);
      chk("rd_fifo", rd_fifo, epop[i]);
      chk("wway", wway, (i == 0) ? ww0 : ww1);
      chk("wstrip", wstrip, ews[i]);
      chk("timed_out", timed_out, 0);
      if (state != S_IDLE) busy++;
      fifo_empty     = (i != 0);
      wdf_rdy        = wdf_s[i];
      rdy            = rdy_s[i];
      rd_data_valid  = val_s[i];
      req_strip_cnt  = SW'(req_s[i]);
      resp_strip_cnt = SW'(resp_s[i]);
      if (i == P + 1) begin fifo_stb = wr; fifo_we = wr; end
      else begin fifo_stb = 1'($urandom); fifo_we = 1'($urandom); end
      step();
    end
    chk("busy_len", busy, len - 1);
    if (exp_busy >= 0) chk("busy_directed", busy, exp_busy);
    exp_pops++;
    exp_ws = wr ? ns : 0;
  endtask

  task automatic do_reset();
    fifo_empty = 1'b1; rd_rst_busy = 1'b0;
    rst = 1'b1; step();
    rst = 1'b0; step();
    exp_pops = 0; exp_ws = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq[5];
    int n;
    seq[0] = 1; seq[1] = 2; seq[2] = 3; seq[3] = 0; seq[4] = 1;

    rst = 1'b1; rdy = 1'b0; wdf_rdy = 1'b0; fifo_empty = 1'b0; rd_rst_busy = 1'b0;
    fifo_stb = 1'b0; fifo_we = 1'b0; rd_data_valid = 1'b0;
    num_strips = '0; req_strip_cnt = '0; resp_strip_cnt = '0;

    // Reset dominates a non-empty FIFO.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_state", state, S_IDLE);
      chk("rst_rd_fifo", rd_fifo, 0);
      chk("rst_wway", wway, 0);
      chk("rst_wstrip", wstrip, 0);
      chk("rst_timed_out", timed_out, 0);
    end
    rst = 1'b0;
    step();
    chk("first_pop_state", state, S_PRE);
    chk("first_pop_rd_fifo", rd_fifo, 1);
    chk("first_pop_wway", wway, 1);
    do_reset();

    // Directed write, three strips, everything ready: 17 cycles IDLE to IDLE.
    run_txn(1'b1, 2, 1, 16);
    // Directed read, four strips, command ready stalled 5 cycles.
    run_txn(1'b0, 3, 2, 13);

    // Way rotation over consecutive single-strip writes.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      run_txn(1'b1, 0, 1, 8);
      chk("wway_seq", wway, seq[k]);
    end

    // Randomized traffic.
    for (int k = 0; k < 12; k++)
      run_txn(1'($urandom), int'($urandom_range(0, 3)), 0, -1);

    // FIFO read-side reset busy blocks the pop.
    rd_rst_busy = 1'b1; fifo_empty = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rrb_state", state, S_IDLE);
      chk("rrb_rd_fifo", rd_fifo, 0);
    end
    rd_rst_busy = 1'b0; fifo_empty = 1'b1;
    step();

    // Reset while waiting for read data.
    fifo_empty = 1'b0; fifo_stb = 1'b0; fifo_we = 1'b0; rdy = 1'b1;
    num_strips = SW'(3); req_strip_cnt = SW'(3); resp_strip_cnt = SW'(3); rd_data_valid = 1'b0;
    step();
    fifo_empty = 1'b1;
    n = 0;
    while (state != S_RD2 && n < 30) begin step(); n++; end
    chk("reach_rd2", state, S_RD2);
    rst = 1'b1;
    step();
    chk("rst_mid_state", state, S_IDLE);
    chk("rst_mid_rd_fifo", rd_fifo, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_state", state, S_IDLE);
      chk("post_rst_rd_fifo", rd_fifo, 0);
    end
    exp_pops = 0; exp_ws = 0;

    // Write with wdf_rdy stuck low.
    fifo_empty = 1'b0; fifo_stb = 1'b1; fifo_we = 1'b1; wdf_rdy = 1'b0; num_strips = '0;
    step();
    fifo_empty = 1'b1;
    n = 0;
    while (state != S_WD0 && n < 30) begin step(); n++; end
    chk("reach_wd0", state, S_WD0);
`ifdef MPMC11_TIMEOUT_EN
    n = 0;
    while (state == S_WD0 && n < 200) begin
      chk("to_wait_pulse", timed_out, 0);
      step(); n++;
    end
    chk("to_wd0_cycles", n, TO);
    chk("to_state", state, S_IDLE);
    chk("to_pulse", timed_out, 1);
    step();
    chk("to_pulse_end", timed_out, 0);
    chk("to_idle_hold", state, S_IDLE);
`else
    for (int i = 0; i < 100; i++) begin
      step();
      chk("stuck_state", state, S_WD0);
      chk("stuck_timed_out", timed_out, 0);
    end
`endif
    do_reset();
    chk("final_state", state, S_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mpmc11_state_machine_wb.md
Name: mpmc11_state_machine_wb

Overview:
- Sequencing state machine for one MPMC11 channel.
- Pops a Wishbone 128-bit request from the channel input FIFO and waits out a parametrised preset delay.
- Issues a multi-strip write or read burst to the memory interface, using its own write-strip counter.
- Adds write-way rotation over NWAY ways and an optional hang time-out. Sits between the channel request FIFO and the shared MIG command/write-data arbiter.

Parameters:
- PRESET_CYCLES, 3: cycles spent in PRESET before DECODE; legal range 1..15.
- NWAY, 4: number of write ways; wway counts modulo NWAY; legal range 2..16.
- STRIP_W, 6: width of strip counts.
- TO_CYCLES, 1024: time-out limit in wait states; only used when MPMC11_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  memory command ready
- wdf_rdy  in  1  write-data FIFO ready
- fifo_empty  in  1  request FIFO empty
- rd_rst_busy  in  1  request FIFO read-side reset busy
- fifo_stb  in  1  stb of the request at the FIFO output
- fifo_we  in  1  we of the request at the FIFO output
- num_strips  in  STRIP_W  last strip index of the burst (burst length minus 1)
- req_strip_cnt  in  STRIP_W  read strips requested so far
- resp_strip_cnt  in  STRIP_W  read strips returned so far
- rd_data_valid  in  1  read data valid
- rd_fifo  out  1  request FIFO pop
- state  out  4  current state
- wway  out  $clog2(NWAY)  current write way
- wstrip  out  STRIP_W  current write strip index
- timed_out  out  1  one-cycle time-out pulse

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on rst. Reset is sampled on clk and dominates all other inputs.
- Reset values: state=IDLE, rd_fifo=0, wway=0, wstrip=0, timed_out=0, preset counter=0, time-out counter=0.
- Reset mid-burst returns the block to IDLE on the next edge with no extra pops.
- State codes, defined in mpmc11_pkg: IDLE=0, PRESET=1, DECODE=2, WRITE_DATA0=3, WRITE_DATA1=4, WRITE_DATA2=5, WRITE_DATA3=6, READ_DATA0=7, READ_DATA1=8, READ_DATA2=9, WAIT_NACK=10. Undefined codes go to IDLE.
- All outputs are registered.
- IDLE: when !fifo_empty && !rd_rst_busy, go to PRESET. rd_fifo=1 for exactly one cycle, the first PRESET cycle. Otherwise stay in IDLE.
- PRESET: lasts exactly PRESET_CYCLES cycles, then DECODE.
  - On the entry cycle: wway increments, wrapping NWAY-1 -> 0; wstrip clears to 0.
- DECODE (1 cycle): if fifo_stb&fifo_we go to WRITE_DATA0, else READ_DATA0.
- WRITE_DATA0: wait for wdf_rdy, then WRITE_DATA1.
- WRITE_DATA1: go to WRITE_DATA2.
- WRITE_DATA2: wait for rdy, then WRITE_DATA3.
- WRITE_DATA3:
  - If wstrip==num_strips, go to IDLE.
  - Else wstrip increments and the block returns to WRITE_DATA0.
  - Each strip therefore takes at least 4 cycles. num_strips=0 gives a single strip.
- READ_DATA0: go to READ_DATA1.
- READ_DATA1: wait for rdy && req_strip_cnt==num_strips, then READ_DATA2.
- READ_DATA2: wait for rd_data_valid && resp_strip_cnt==num_strips, then WAIT_NACK.
- WAIT_NACK: go to IDLE.
- Minimum request-to-IDLE time, with all ready inputs high:
  - write of 1 strip: 1+PRESET_CYCLES+1+4 cycles;
  - read: 1+PRESET_CYCLES+1+4 cycles.
- No new pop occurs until the block is back in IDLE: back-to-back requests need at least one IDLE cycle.
- Inputs that change while the block is outside IDLE are ignored, except for the wait conditions listed above.

Optional Feature:
- Macro name: MPMC11_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on every state change and counts while state is held in WRITE_DATA0, WRITE_DATA2, READ_DATA1 or READ_DATA2.
  - When the counter reaches TO_CYCLES-1, next state is IDLE and timed_out pulses 1 for one cycle. The time-out takes priority over that cycle's normal transition.
- When undefined: no counter, timed_out is held at 0, and wait states may hold forever.

Test Plan:
- Reset held for 3 cycles with fifo_empty=0 -> state=0, rd_fifo=0, wway=0 throughout; first pop on the cycle after rst falls.
- Write, num_strips=2, PRESET_CYCLES=3, all ready inputs high -> rd_fifo pulses once; wstrip goes 0,1,2; 12 write-state cycles; IDLE after 17 cycles; wway=1.
- Read, num_strips=3, rdy=0 for 5 cycles with req_strip_cnt=3 -> READ_DATA1 is held 5 extra cycles; then rd_data_valid with resp_strip_cnt=3 -> WAIT_NACK -> IDLE.
- 5 consecutive single-strip writes with NWAY=4 -> wway sequence 1,2,3,0,1.
- MPMC11_TIMEOUT_EN with TO_CYCLES=8, wdf_rdy stuck at 0 -> IDLE after 8 cycles in WRITE_DATA0, timed_out high for one cycle; without the macro the block stays in WRITE_DATA0 for 100 cycles.
- rd_rst_busy=1 with fifo_empty=0 -> block stays in IDLE with no pop; rst asserted in READ_DATA2 -> IDLE on the next cycle.
